fft_iter_addr_gen: RTL and testbench

//  Address generator for the iterative radix-2 DIT FFT engine. Sits directly downstream of the

---
 rtl/fft_iter_addr_gen.sv | 122 ++++++++++++
 tb/tb_fft_iter_addr_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_iter_addr_gen.sv
// Address generator for the iterative radix-2 DIT FFT: tracks butterfly/layer position
// from the control unit strobes and produces registered data-RAM and twiddle-ROM addresses.
module fft_iter_addr_gen #(
  parameter int unsigned LAYERS      = 5,
  parameter int unsigned BUTTERFLYES = 16,
  parameter int unsigned LayWL       = 3,
  parameter int unsigned ButtWL      = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              START,
  input  logic              ADDR_EN,
  input  logic              LAY_EN,
  output logic [LAYERS-1:0] RD_ADDR_A,
  output logic [LAYERS-1:0] RD_ADDR_B,
  output logic [LAYERS-1:0] WR_ADDR_A,
  output logic [LAYERS-1:0] WR_ADDR_B,
  output logic [ButtWL-1:0] TW_ADDR,
  output logic [LayWL-1:0]  LAYER,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ButtWL-1:0] b_q, b_d;
  logic [LayWL-1:0]  l_q, l_d;
  logic              err_d;
  logic              done_d;
  logic              upd_addr;

  logic [LAYERS-1:0] span, pos, grp, addr_a, addr_b;
  logic [ButtWL-1:0] tw;

  function automatic logic [LAYERS-1:0] bitrev(input logic [LAYERS-1:0] x);
    logic [LAYERS-1:0] r;
    for (int i = 0; i < LAYERS; i++) r[i] = x[LAYERS-1-i];
    return r;
  endfunction

  // Next-state: START has priority; layer advance resets the butterfly counter
  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    l_d      = l_q;
    err_d    = ERR;
    done_d   = 1'b0;
    upd_addr = 1'b0;
    if (START) begin
      state_d  = ST_RUN;
      b_d      = '0;
      l_d      = '0;
      err_d    = 1'b0;
      upd_addr = 1'b1;
    end else if (ADDR_EN) begin
      if (state_q == ST_RUN) begin
        upd_addr = 1'b1;
        if (LAY_EN) begin
          b_d = '0;
          if (b_q != ButtWL'(BUTTERFLYES-1)) err_d = 1'b1;
          if (l_q == LayWL'(LAYERS-1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            l_d = l_q + LayWL'(1);
          end
        end else begin
          b_d = b_q + ButtWL'(1);
        end
      end
    end else if (LAY_EN) begin
      err_d = 1'b1;
    end
  end

  // Butterfly operand and twiddle addresses from the next-state position
  always_comb begin
    span   = LAYERS'(1) << l_d;
    pos    = LAYERS'(b_d) & (span - LAYERS'(1));
    grp    = LAYERS'(b_d) >> l_d;
    addr_a = (grp << (l_d + LayWL'(1))) | pos;
    addr_b = addr_a + span;
    tw     = ButtWL'(pos << (LayWL'(LAYERS-1) - l_d));
  end

  // State and registered outputs; addresses only move on START or an accepted advance
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      b_q       <= '0;
      l_q       <= '0;
      RD_ADDR_A <= '0;
      RD_ADDR_B <= '0;
      WR_ADDR_A <= '0;
      WR_ADDR_B <= '0;
      TW_ADDR   <= '0;
      LAYER     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else if (EN) begin
      state_q <= state_d;
      b_q     <= b_d;
      l_q     <= l_d;
      LAYER   <= l_d;
      BUSY    <= (state_d == ST_RUN);
      DONE    <= done_d;
      ERR     <= err_d;
      if (upd_addr) begin
        WR_ADDR_A <= addr_a;
        WR_ADDR_B <= addr_b;
        TW_ADDR   <= tw;
        RD_ADDR_A <= (l_d == '0) ? bitrev(addr_a) : addr_a;
        RD_ADDR_B <= (l_d == '0) ? bitrev(addr_b) : addr_b;
      end
    end
  end

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Self-checking bench for fft_iter_addr_gen: scoreboard of expected outputs plus
// directed constant checks for the documented address examples.
module tb_fft_iter_addr_gen;

  localparam int unsigned L  = 5;
  localparam int unsigned BF = 16;
  localparam int unsigned LW = 3;
  localparam int unsigned BW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          EN = 1'b0, START = 1'b0, ADDR_EN = 1'b0, LAY_EN = 1'b0;
  logic [L-1:0]  RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
  logic [BW-1:0] TW_ADDR;
  logic [LW-1:0] LAYER;
  logic          BUSY, DONE, ERR;

  typedef struct packed {
    logic [L-1:0]  rd_a, rd_b, wr_a, wr_b;
    logic [BW-1:0] tw;
    logic [LW-1:0] layer;
    logic          busy, done, err;
  } out_t;

  out_t exp_q[$];
  out_t m_out;
  int   m_b, m_l;
  bit   m_busy, m_err;
  int   n_checks = 0, n_pass = 0;

  fft_iter_addr_gen #(.LAYERS(L), .BUTTERFLYES(BF), .LayWL(LW), .ButtWL(BW)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .START(START), .ADDR_EN(ADDR_EN), .LAY_EN(LAY_EN),
    .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B), .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B),
    .TW_ADDR(TW_ADDR), .LAYER(LAYER), .BUSY(BUSY), .DONE(DONE), .ERR(ERR));

  always #5 CLK = ~CLK;

  function automatic out_t actual();
    out_t a;
    a = '{RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, TW_ADDR, LAYER, BUSY, DONE, ERR};
    return a;
  endfunction

  // A: butterfly index with a 0 bit inserted at position l
  function automatic int model_a(input int b, input int l);
    int r = 0;
    for (int i = 0; i < L; i++) begin
      int bit_v;
      if (i < l)       bit_v = (b >> i) & 1;
      else if (i == l) bit_v = 0;
      else             bit_v = (b >> (i - 1)) & 1;
      r = r + (bit_v << i);
    end
    return r;
  endfunction

  function automatic int model_rev(input int x);
    int r = 0;
    for (int i = 0; i < L; i++) if (((x >> i) & 1) == 1) r = r + (1 << (L - 1 - i));
    return r;
  endfunction

  function automatic void model_reset();
    m_b = 0; m_l = 0; m_busy = 0; m_err = 0;
    m_out = '0;
  endfunction

  function automatic void model_step(input bit en, input bit st, input bit ae, input bit le);
    bit upd = 0, dn = 0;
    int a, b;
    if (!en) return;
    if (st) begin
      m_busy = 1; m_b = 0; m_l = 0; m_err = 0; upd = 1;
    end else if (ae) begin
      if (m_busy) begin
        upd = 1;
        if (le) begin
          if (m_b != BF - 1) m_err = 1;
          m_b = 0;
          if (m_l == L - 1) begin m_busy = 0; dn = 1; end
          else m_l = m_l + 1;
        end else m_b = (m_b + 1) % BF;
      end
    end else if (le) m_err = 1;
    m_out.busy  = m_busy;
    m_out.done  = dn;
    m_out.err   = m_err;
    m_out.layer = LW'(m_l);
    if (upd) begin
      a = model_a(m_b, m_l);
      b = a + (1 << m_l);
      m_out.wr_a = L'(a);
      m_out.wr_b = L'(b);
      m_out.rd_a = L'((m_l == 0) ? model_rev(a) : a);
      m_out.rd_b = L'((m_l == 0) ? model_rev(b) : b);
      m_out.tw   = BW'((m_b % (1 << m_l)) * (1 << (L - 1 - m_l)));
    end
  endfunction

  // Drive strobes on the falling edge, as the control unit does; queue the expectation
  task automatic step(input bit en, input bit st, input bit ae, input bit le);
    @(negedge CLK);
    EN = en; START = st; ADDR_EN = ae; LAY_EN = le;
    model_step(en, st, ae, le);
    exp_q.push_back(m_out);
    @(posedge CLK);
    #2;
    EN = 1'b1; START = 1'b0; ADDR_EN = 1'b0; LAY_EN = 1'b0;
  endtask

  // Scoreboard: pop one expectation per clock once something has been driven
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        out_t e, a;
        e = exp_q.pop_front();
        a = actual();
        n_checks++;
        if (a !== e) $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, a, e);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    out_t a;
    RST_N = 1'b0;
    #1;
    a = actual();
    n_checks++;
    if (a !== out_t'(0)) $display("FAIL reset_initial actual=%h required=0", a);
    else n_pass++;
    @(negedge CLK);
    RST_N = 1'b1;
    EN = 1'b1;
    model_reset();
    step(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 1, (i == 15));
    n_checks++;
    if (BUSY !== 1'b1 || LAYER !== 3'd1) $display("FAIL reset_pre_busy actual=%b/%0d required=1/1", BUSY, LAYER);
    else n_pass++;
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    a = actual();
    n_checks++;
    if (a !== out_t'(0)) $display("FAIL reset_midrun actual=%h required=0", a);
    else n_pass++;
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    step(1, 0, 1, 0);
    n_checks++;
    if (BUSY !== 1'b0 || WR_ADDR_B !== 5'd0) $display("FAIL reset_needs_start actual=%b/%0d required=0/0", BUSY, WR_ADDR_B);
    else n_pass++;
  endtask

  task automatic test_layer0();
    step(1, 1, 0, 0);
    n_checks++;
    if ({RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, TW_ADDR} !== {5'd0, 5'd16, 5'd0, 5'd1, 4'd0})
      $display("FAIL start_addr actual=%0d,%0d,%0d,%0d,%0d required=0,16,0,1,0",
               RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, TW_ADDR);
    else n_pass++;
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
    n_checks++;
    if ({RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, TW_ADDR} !== {5'd12, 5'd28, 5'd6, 5'd7, 4'd0})
      $display("FAIL b3_addr actual=%0d,%0d,%0d,%0d,%0d required=12,28,6,7,0",
               RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, TW_ADDR);
    else n_pass++;
  endtask

  task automatic test_layer2();
    step(1, 1, 0, 0);
    for (int i = 0; i < 32; i++) step(1, 0, 1, (i % 16) == 15);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
    n_checks++;
    if ({RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, TW_ADDR, LAYER} !==
        {5'd9, 5'd13, 5'd9, 5'd13, 4'd4, 3'd2})
      $display("FAIL l2_b5 actual=%0d,%0d,%0d,%0d,%0d,%0d required=9,13,9,13,4,2",
               RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, TW_ADDR, LAYER);
    else n_pass++;
  endtask

  task automatic test_full_run();
    int done_cnt = 0, done_at = -1;
    bit busy_before = 0, busy_after = 1;
    step(1, 1, 0, 0);
    for (int i = 0; i < 80; i++) begin
      step(1, 0, 1, (i % 16) == 15);
      if (DONE === 1'b1) begin done_cnt++; done_at = i; end
      if (i == 78) busy_before = BUSY;
      if (i == 79) busy_after = BUSY;
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      if (DONE === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 1 || done_at != 79) $display("FAIL done_pulse actual=%0d@%0d required=1@79", done_cnt, done_at);
    else n_pass++;
    n_checks++;
    if (busy_before !== 1'b1 || busy_after !== 1'b0 || ERR !== 1'b0)
      $display("FAIL busy_drop actual=%b%b err=%b required=10 err=0", busy_before, busy_after, ERR);
    else n_pass++;
  endtask

  task automatic test_err();
    step(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    n_checks++;
    if ({ERR, LAYER, WR_ADDR_A, WR_ADDR_B} !== {1'b1, 3'd1, 5'd0, 5'd2})
      $display("FAIL premature_lay actual=%b,%0d,%0d,%0d required=1,1,0,2", ERR, LAYER, WR_ADDR_A, WR_ADDR_B);
    else n_pass++;
    for (int i = 0; i < 16; i++) step(1, 0, 1, (i == 15));
    n_checks++;
    if (ERR !== 1'b1) $display("FAIL err_sticky actual=%b required=1", ERR);
    else n_pass++;
    step(1, 1, 0, 0);
    n_checks++;
    if (ERR !== 1'b0) $display("FAIL err_clear actual=%b required=0", ERR);
    else n_pass++;
    step(1, 0, 0, 1);
    n_checks++;
    if (ERR !== 1'b1 || WR_ADDR_B !== 5'd1) $display("FAIL lay_alone actual=%b/%0d required=1/1", ERR, WR_ADDR_B);
    else n_pass++;
  endtask

  task automatic test_en_hold();
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, i[0], i[1], i[2]);
    n_checks++;
    if ({WR_ADDR_A, WR_ADDR_B, RD_ADDR_A, BUSY, ERR} !== {5'd4, 5'd5, 5'd4, 1'b1, 1'b0})
      $display("FAIL en_hold actual=%0d,%0d,%0d,%b,%b required=4,5,4,1,0",
               WR_ADDR_A, WR_ADDR_B, RD_ADDR_A, BUSY, ERR);
    else n_pass++;
    step(1, 1, 1, 0);
    n_checks++;
    if ({WR_ADDR_A, WR_ADDR_B} !== {5'd0, 5'd1}) $display("FAIL start_wins actual=%0d,%0d required=0,1", WR_ADDR_A, WR_ADDR_B);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      bit en = ($urandom_range(0, 9) != 0);
      bit st = ($urandom_range(0, 59) == 0);
      bit ae = ($urandom_range(0, 3) != 0);
      bit le = ae ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0);
      step(en, st, ae, le);
    end
  endtask

  initial begin
    test_reset();
    test_layer0();
    test_layer2();
    test_full_run();
    test_err();
    test_en_hold();
    test_back_to_back();
    @(posedge CLK);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
